// File: rtl/cv32e40p_apu_wb_arbiter_if.sv
// Writeback arbiter bus: LSU/APU result inputs, ID read addresses,
// regfile write port and status back to EX/ID.
// master = EX/ID side (drives results and read addresses), slave = arbiter.
interface cv32e40p_apu_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  lsu_we_i;
    logic [ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic                  apu_rvalid_i;
    logic [ADDR_WIDTH-1:0] apu_waddr_i;
    logic [DATA_WIDTH-1:0] apu_result_i;
    logic [4:0]            apu_flags_i;
    logic [ADDR_WIDTH-1:0] raddr_a_i;
    logic [ADDR_WIDTH-1:0] raddr_b_i;
    logic [ADDR_WIDTH-1:0] raddr_c_i;
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic                  fflags_we_o;
    logic [4:0]            fflags_o;
    logic                  apu_stall_o;
    logic                  apu_busy_o;
    logic                  apu_read_dep_o;
    logic                  overflow_o;

    modport master (
        output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        output apu_rvalid_i, apu_waddr_i, apu_result_i, apu_flags_i,
        output raddr_a_i, raddr_b_i, raddr_c_i,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, fflags_we_o, fflags_o,
        input  apu_stall_o, apu_busy_o, apu_read_dep_o, overflow_o
    );

    modport slave (
        input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        input  apu_rvalid_i, apu_waddr_i, apu_result_i, apu_flags_i,
        input  raddr_a_i, raddr_b_i, raddr_c_i,
        output rf_we_o, rf_waddr_o, rf_wdata_o, fflags_we_o, fflags_o,
        output apu_stall_o, apu_busy_o, apu_read_dep_o, overflow_o
    );
endinterface

// File: rtl/cv32e40p_apu_wb_arbiter.sv
// APU/LSU writeback arbiter. LSU loads always win the regfile write port;
// APU results that cannot write immediately are queued in an in-order
// circular buffer and drained whenever the LSU is idle. Buffered entries
// overwritten by a later LSU write to the same register are killed and
// drained silently.
// Optional feature macro: CV32E40P_APU_WB_BYPASS_EN -- when defined, an APU
// result arriving with an empty buffer and an idle LSU writes in the same
// cycle instead of being queued.
module cv32e40p_apu_wb_arbiter #(
    parameter int APU_BUF_DEPTH = 2,
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    cv32e40p_apu_wb_arbiter_if.slave wb
);
    localparam int PTR_W = (APU_BUF_DEPTH > 1) ? $clog2(APU_BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(APU_BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(APU_BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(APU_BUF_DEPTH - 1);

    // Buffer storage (not reset; validity comes from pointers and count)
    logic [ADDR_WIDTH-1:0] waddr_mem [APU_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem  [APU_BUF_DEPTH];
    logic [4:0]            flags_mem [APU_BUF_DEPTH];

    logic [APU_BUF_DEPTH-1:0] kill_q, kill_d;
    logic [PTR_W-1:0]         rptr_q, rptr_d;
    logic [PTR_W-1:0]         wptr_q, wptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     overflow_q, overflow_d;

    logic [APU_BUF_DEPTH-1:0] entry_valid;
    logic [APU_BUF_DEPTH-1:0] kill_hit;
    logic [APU_BUF_DEPTH-1:0] dep_hit;
    logic [CNT_W-1:0]         entry_off [APU_BUF_DEPTH];

    logic buf_empty;
    logic pop;
    logic bypass;
    logic push_req;
    logic push;
    logic drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Per-entry validity (distance from read pointer below occupancy),
    // LSU WAW match and operand read-dependency match.
    genvar gi;
    generate
        for (gi = 0; gi < APU_BUF_DEPTH; gi++) begin : g_entry
            assign entry_off[gi] = (PTR_W'(gi) >= rptr_q)
                                 ? (CNT_W'(gi) - CNT_W'(rptr_q))
                                 : (CNT_W'(gi) + DEPTH_C - CNT_W'(rptr_q));
            assign entry_valid[gi] = (entry_off[gi] < cnt_q);
            assign kill_hit[gi] = wb.lsu_we_i && entry_valid[gi] &&
                                  (waddr_mem[gi] == wb.lsu_waddr_i);
            assign dep_hit[gi] = entry_valid[gi] && !kill_q[gi] &&
                                 ((waddr_mem[gi] == wb.raddr_a_i) ||
                                  (waddr_mem[gi] == wb.raddr_b_i) ||
                                  (waddr_mem[gi] == wb.raddr_c_i));
        end
    endgenerate

    // Buffer control: pop when LSU idle, push unless bypassed, drop when full
    always_comb begin
        buf_empty = (cnt_q == '0);
        pop       = !wb.lsu_we_i && !buf_empty;
`ifdef CV32E40P_APU_WB_BYPASS_EN
        bypass    = wb.apu_rvalid_i && buf_empty && !wb.lsu_we_i;
`else
        bypass    = 1'b0;
`endif
        push_req  = wb.apu_rvalid_i && !bypass;
        push      = push_req && ((cnt_q != DEPTH_C) || pop);
        drop      = push_req && (cnt_q == DEPTH_C) && !pop;

        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end

        overflow_d = overflow_q | drop;

        // A freshly written slot never inherits a stale kill mark
        kill_d = kill_q | kill_hit;
        if (push) begin
            kill_d[wptr_q] = 1'b0;
        end
    end

    // Pointer, occupancy, kill and sticky overflow state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            kill_q     <= '0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            kill_q     <= kill_d;
        end
    end

    // Buffer payload write
    always_ff @(posedge clk_i) begin
        if (push) begin
            waddr_mem[wptr_q] <= wb.apu_waddr_i;
            data_mem[wptr_q]  <= wb.apu_result_i;
            flags_mem[wptr_q] <= wb.apu_flags_i;
        end
    end

    // Regfile write-port mux: LSU, then buffer head, then (optionally) bypass
    always_comb begin
        wb.rf_we_o     = 1'b0;
        wb.rf_waddr_o  = '0;
        wb.rf_wdata_o  = '0;
        wb.fflags_we_o = 1'b0;
        wb.fflags_o    = '0;
        if (wb.lsu_we_i) begin
            wb.rf_we_o    = 1'b1;
            wb.rf_waddr_o = wb.lsu_waddr_i;
            wb.rf_wdata_o = wb.lsu_wdata_i;
        end else if (!buf_empty) begin
            if (!kill_q[rptr_q]) begin
                wb.rf_we_o     = 1'b1;
                wb.rf_waddr_o  = waddr_mem[rptr_q];
                wb.rf_wdata_o  = data_mem[rptr_q];
                wb.fflags_we_o = 1'b1;
                wb.fflags_o    = flags_mem[rptr_q];
            end
        end else if (bypass) begin
            wb.rf_we_o     = 1'b1;
            wb.rf_waddr_o  = wb.apu_waddr_i;
            wb.rf_wdata_o  = wb.apu_result_i;
            wb.fflags_we_o = 1'b1;
            wb.fflags_o    = wb.apu_flags_i;
        end
    end

    // Status back to EX/ID
    always_comb begin
        wb.apu_stall_o    = (cnt_q >= (DEPTH_C - 1'b1));
        wb.apu_busy_o     = !buf_empty;
        wb.overflow_o     = overflow_q;
        wb.apu_read_dep_o = (|dep_hit) ||
                            (wb.apu_rvalid_i &&
                             ((wb.apu_waddr_i == wb.raddr_a_i) ||
                              (wb.apu_waddr_i == wb.raddr_b_i) ||
                              (wb.apu_waddr_i == wb.raddr_c_i)));
    end
endmodule
